// File: rtl/ofmap_pack_writer.sv
// Bit-level gearbox: packs 144-bit result beats (with optional per-lane ReLU) into
// 256-bit DDR words; a flush drains the residue as a zero-padded word tagged last.
module ofmap_pack_writer #(
    parameter int IN_W    = 144,
    parameter int LANE_W  = 8,
    parameter int OUT_W   = 256,
    parameter int BUF_W   = 512,
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              flush_done,
    output logic [CNT_W-1:0]  out_word_cnt
);
    localparam int LANES  = IN_W / LANE_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] IN_LIMIT = FILL_W'(BUF_W - IN_W);
    localparam logic [FILL_W-1:0] OUT_STEP = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_STEP  = FILL_W'(IN_W);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state_reg;
    logic [BUF_W-1:0]   buf_reg;
    logic [BUF_W-1:0]   buf_shifted;
    logic [BUF_W-1:0]   buf_next;
    logic [FILL_W-1:0]  fill_reg;
    logic [FILL_W-1:0]  fill_mid;
    logic [FILL_W-1:0]  fill_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic [IN_W-1:0]    relu_data;
    logic               in_fire;
    logic               out_fire;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane;
            assign lane = in_data[gi*LANE_W +: LANE_W];
            if (RELU_EN != 0) begin : g_relu
                assign relu_data[gi*LANE_W +: LANE_W] = lane[LANE_W-1] ? '0 : lane;
            end else begin : g_pass
                assign relu_data[gi*LANE_W +: LANE_W] = lane;
            end
        end
    endgenerate

    assign in_ready     = (state_reg == RUN) && (fill_reg <= IN_LIMIT);
    assign out_valid    = (fill_reg >= OUT_STEP) || ((state_reg == FLUSH) && (fill_reg != '0));
    assign out_last     = out_valid && (state_reg == FLUSH) && (fill_reg <= OUT_STEP);
    assign out_data     = buf_reg[OUT_W-1:0];
    assign flush_done   = done_reg;
    assign out_word_cnt = cnt_reg;
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;

    // Drain first, then append the new beat just above the surviving bits; bits above
    // fill stay zero, which is what pads the final partial word.
    always_comb begin
        buf_shifted = buf_reg;
        fill_mid    = fill_reg;
        if (out_fire) begin
            buf_shifted = buf_reg >> OUT_W;
            fill_mid    = (fill_reg >= OUT_STEP) ? (fill_reg - OUT_STEP) : '0;
        end
        buf_next  = buf_shifted;
        fill_next = fill_mid;
        if (in_fire) begin
            buf_next  = buf_shifted | ({{(BUF_W-IN_W){1'b0}}, relu_data} << fill_mid);
            fill_next = fill_mid + IN_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            buf_reg   <= '0;
            fill_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            buf_reg  <= buf_next;
            fill_reg <= fill_next;
            done_reg <= 1'b0;
            if (out_fire) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // An empty buffer at flush time completes immediately without visiting FLUSH.
            if (state_reg == RUN) begin
                if (flush_in) begin
                    if (fill_next == '0) begin
                        done_reg <= 1'b1;
                        cnt_reg  <= '0;
                    end else begin
                        state_reg <= FLUSH;
                    end
                end
            end else begin
                if (fill_next == '0) begin
                    state_reg <= RUN;
                    done_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ofmap_pack_writer.sv
// Directed bench for ofmap_pack_writer: bitstream packing, backpressure, flush, ReLU, reset.
module tb_ofmap_pack_writer;
    localparam int IN_W  = 144;
    localparam int OUT_W = 256;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             flush_in;
    logic             out_ready;
    logic             in_ready,   p_in_ready;
    logic [OUT_W-1:0] out_data,   p_out_data;
    logic             out_valid,  p_out_valid;
    logic             out_last,   p_out_last;
    logic             flush_done, p_flush_done;
    logic [CNT_W-1:0] out_word_cnt, p_out_word_cnt;

    ofmap_pack_writer #(.RELU_EN(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush_in(flush_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .flush_done(flush_done), .out_word_cnt(out_word_cnt)
    );

    ofmap_pack_writer #(.RELU_EN(0)) dut_pass (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(p_in_ready),
        .flush_in(flush_in), .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(out_ready),
        .out_last(p_out_last), .flush_done(p_flush_done), .out_word_cnt(p_out_word_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Monitor state, sampled on the falling edge
    int               cyc = 0;
    logic [OUT_W-1:0] words[$];
    logic             lasts[$];
    logic [OUT_W-1:0] p_words[$];
    logic             p_lasts[$];
    int               acc_cnt;
    int               fire_cyc;
    int               done_cyc;
    int               flush_cyc;
    int               cnt_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                words.push_back(out_data);
                lasts.push_back(out_last);
                fire_cyc = cyc;
                $display("[TB] word %0d data=%h last=%0d cnt=%0d", words.size() - 1, out_data, out_last, out_word_cnt);
            end
            if (p_out_valid && out_ready) begin
                p_words.push_back(p_out_data);
                p_lasts.push_back(p_out_last);
            end
            if (in_valid && in_ready) acc_cnt++;
            if (flush_in) flush_cyc = cyc;
            if (flush_done) begin
                done_cyc    = cyc;
                cnt_at_done = int'(out_word_cnt);
            end
        end
    end

    task automatic check_vec(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] word_at(input int i);
        if (i < words.size()) return words[i];
        return 'x;
    endfunction

    function automatic logic [IN_W-1:0] beat(input int b);
        logic [IN_W-1:0] r;
        for (int k = 0; k < 18; k++) r[k*8 +: 8] = 8'((b * 18 + k) % 128);
        return r;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush_in = 1'b0; out_ready = 1'b1; in_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        words.delete(); lasts.delete(); p_words.delete(); p_lasts.delete();
        acc_cnt = 0; fire_cyc = -1; done_cyc = -1; flush_cyc = -1; cnt_at_done = -1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d);
        bit ok = 0;
        in_data = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check_int("send_beat_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_beat_flush(input logic [IN_W-1:0] d);
        in_data = d; in_valid = 1'b1; flush_in = 1'b1;
        @(negedge clk);
        check_int("beat_flush_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0; flush_in = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_in = 1'b1;
        @(posedge clk);
        #1 flush_in = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (flush_done) begin ok = 1; break; end
        end
        #1;
        check_int(nm, int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] relu_w;
        logic [OUT_W-1:0] pass_w;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [16*IN_W-1:0] stream;
        logic [4*IN_W-1:0]  s4;
        logic [OUT_W-1:0]   held;
        int                 rdy_seen;
        int                 unstable;

        vecs[0] = '{din: 144'h7F00FF80, relu_w: 256'h7F000000, pass_w: 256'h7F00FF80};
        vecs[1] = '{din: {18{8'h81}}, relu_w: 256'h0, pass_w: {112'h0, {18{8'h81}}}};
        vecs[2] = '{din: {8'h7F, 8'h80, {16{8'h40}}},
                    relu_w: {112'h0, 8'h7F, 8'h00, {16{8'h40}}},
                    pass_w: {112'h0, 8'h7F, 8'h80, {16{8'h40}}}};
        vecs[3] = '{din: {64'h0, 8'h01, 64'h0, 8'hFF},
                    relu_w: {112'h0, 64'h0, 8'h01, 72'h0},
                    pass_w: {112'h0, 64'h0, 8'h01, 64'h0, 8'hFF}};

        // Reset state
        do_reset();
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_in_ready", int'(in_ready), 1);
        check_int("rst_out_last", int'(out_last), 0);
        check_int("rst_flush_done", int'(flush_done), 0);
        check_int("rst_word_cnt", int'(out_word_cnt), 0);

        // T1: 16 beats produce 9 words carrying the concatenated bitstream
        for (int b = 0; b < 16; b++) begin
            stream[b*IN_W +: IN_W] = beat(b);
            send_beat(beat(b));
        end
        repeat (5) @(posedge clk);
        #1;
        check_int("t1_word_count", words.size(), 9);
        for (int w = 0; w < 9; w++) begin
            check_vec($sformatf("t1_word%0d", w), word_at(w), stream[w*OUT_W +: OUT_W]);
            if (w < lasts.size()) check_int($sformatf("t1_last%0d", w), int'(lasts[w]), 0);
        end
        check_int("t1_word_cnt", int'(out_word_cnt), 9);
        check_int("t1_drained", int'(out_valid), 0);

        // T2: stalled output lets exactly 3 beats in, then resumes without loss
        do_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) s4[b*IN_W +: IN_W] = beat(b + 20);
        for (int b = 0; b < 3; b++) send_beat(beat(b + 20));
        in_data = beat(23);
        in_valid = 1'b1;
        rdy_seen = 0;
        unstable = 0;
        held = out_data;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) rdy_seen++;
            if (out_data !== held || !out_valid) unstable++;
        end
        check_int("t2_accepted", acc_cnt, 3);
        check_int("t2_in_ready_low", rdy_seen, 0);
        check_int("t2_out_valid", int'(out_valid), 1);
        check_int("t2_stable", unstable, 0);
        check_vec("t2_held_word", held, s4[OUT_W-1:0]);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_beat(beat(23));
        pulse_flush();
        wait_done("t2_flush_done");
        check_int("t2_accepted_total", acc_cnt, 4);
        check_int("t2_word_count", words.size(), 3);
        check_vec("t2_word0", word_at(0), s4[OUT_W-1:0]);
        check_vec("t2_word1", word_at(1), s4[2*OUT_W-1:OUT_W]);
        check_vec("t2_word2", word_at(2), {192'h0, s4[4*IN_W-1:2*OUT_W]});
        if (lasts.size() == 3) begin
            check_int("t2_last1", int'(lasts[1]), 0);
            check_int("t2_last2", int'(lasts[2]), 1);
        end

        // T3: one beat, then flush in a later cycle
        do_reset();
        send_beat(beat(40));
        pulse_flush();
        wait_done("t3_flush_done");
        check_int("t3_word_count", words.size(), 1);
        check_vec("t3_word", word_at(0), {112'h0, beat(40)});
        if (lasts.size() == 1) check_int("t3_last", int'(lasts[0]), 1);
        check_int("t3_done_timing", done_cyc, fire_cyc + 1);
        check_int("t3_cnt_cleared", cnt_at_done, 0);
        check_int("t3_done_pulse", int'(flush_done), 0);

        // T5a: flush on an empty buffer
        do_reset();
        pulse_flush();
        wait_done("t5_flush_done");
        check_int("t5_done_timing", done_cyc, flush_cyc + 1);
        check_int("t5_no_word", words.size(), 0);

        // T4/T5b: ReLU table, each beat sent in the same cycle as flush_in
        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_beat_flush(vecs[v].din);
            wait_done($sformatf("t4_v%0d_done", v));
            check_int($sformatf("t4_v%0d_count", v), words.size(), 1);
            check_vec($sformatf("t4_v%0d_relu", v), word_at(0), vecs[v].relu_w);
            if (p_words.size() == 1) begin
                check_vec($sformatf("t4_v%0d_pass", v), p_words[0], vecs[v].pass_w);
                check_int($sformatf("t4_v%0d_plast", v), int'(p_lasts[0]), 1);
            end else begin
                check_int($sformatf("t4_v%0d_pcount", v), p_words.size(), 1);
            end
            if (lasts.size() == 1) check_int($sformatf("t4_v%0d_last", v), int'(lasts[0]), 1);
            check_int($sformatf("t4_v%0d_pcnt", v), int'(p_out_word_cnt), 0);
            check_int($sformatf("t4_v%0d_pready", v), int'(p_in_ready), 1);
        end

        // T6: reset mid-operation with a stalled word
        do_reset();
        out_ready = 1'b0;
        send_beat(beat(60));
        send_beat(beat(61));
        check_int("t6_pre_valid", int'(out_valid), 1);
        check_int("t6_pre_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_int("t6_out_valid", int'(out_valid), 0);
        check_int("t6_in_ready", int'(in_ready), 1);
        check_int("t6_out_last", int'(out_last), 0);
        words.delete(); lasts.delete(); p_words.delete(); p_lasts.delete();
        out_ready = 1'b1;
        send_beat_flush(beat(62));
        wait_done("t6_flush_done");
        check_int("t6_word_count", words.size(), 1);
        check_vec("t6_word", word_at(0), {112'h0, beat(62)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
